ex_pipe_regs: RTL and testbench
===============================

EX_PIPE_REGS -- requirements
Module: ex_pipe_regs

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of operand/result fields.
REQ-002 Parameter RA_W, default 4, register-address width.
REQ-003 clk  in  1  single system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 RA1D, RA2D, WA3D  in  RA_W each  decode-stage source/destination register addresses.
REQ-006 RegWriteD, MemtoRegD  in  1 each  decode-stage control bits.
REQ-007 RD1D, RD2D, ExtImmD  in  DATA_W each  decode-stage operands.
REQ-008 FlushE  in  1  external flush of the execute slot (taken branch).
REQ-009 ALUResultE  in  DATA_W  execute-stage result.
REQ-010 ReadDataM  in  DATA_W  memory read data for the M-stage instruction.
REQ-011 RA1E, RA2E, WA3E, RD1E, RD2E, ExtImmE, RegWriteE, MemtoRegE  out  per source field  E-stage register contents.
REQ-012 ALUOutM, WA3M, RegWriteM, MemtoRegM  out  per source field  M-stage register contents.
REQ-013 ResultW, WA3W, RegWriteW  out  DATA_W / RA_W / 1  W-stage register contents.
REQ-014 Match  out  4  {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W}, MSB first.
REQ-015 StallF, StallD  out  1 each  load-use stall request to fetch/decode.

Function
REQ-016 D->E register SHALL load all D-stage fields every cycle unless a bubble is inserted.
REQ-017 Bubble condition SHALL be FlushE | ldrStall; a bubble SHALL clear RegWriteE, MemtoRegE, WA3E, RA1E, RA2E to 0 (data fields may hold any value).
REQ-018 E->M register SHALL load ALUResultE, WA3E, RegWriteE, MemtoRegE every cycle, no stall or flush.
REQ-019 M->W register SHALL load ResultW = MemtoRegM ? ReadDataM : ALUOutM, plus WA3M, RegWriteM, every cycle.
REQ-020 Match bits SHALL be combinational equality of registered addresses: Match_1E_M = (RA1E==WA3M), Match_1E_W = (RA1E==WA3W), Match_2E_M = (RA2E==WA3M), Match_2E_W = (RA2E==WA3W); not gated by RegWrite (gating is done downstream).
REQ-021 ldrStall SHALL be combinational: ((RA1D==WA3E)|(RA2D==WA3E)) & MemtoRegE & RegWriteE.
REQ-022 StallF = StallD = ldrStall, same cycle, zero latency.
REQ-023 Latency: D fields appear at E outputs 1 cycle after capture, at M after 2, W after 3.
REQ-024 FlushE and ldrStall simultaneous SHALL yield a single bubble, identical to either alone.
REQ-025 ldrStall SHALL last exactly one cycle per load-use pair (the bubble clears MemtoRegE next cycle).
REQ-026 Address 0 SHALL get no special treatment; equality applies to all values.

Reset
REQ-027 While reset==0 every register SHALL be 0 asynchronously: all E/M/W outputs 0, Match = 4'b1111 (all addresses equal 0), StallF = StallD = 0.
REQ-028 Reset mid-operation SHALL discard all in-flight instructions; first capture occurs on the first rising clk edge after reset returns to 1.

Structure
REQ-029 A shared package SHALL hold DATA_W/RA_W defaults and the Match bit-index constants (M1EM=3, M1EW=2, M2EM=1, M2EW=0) used by this block and the hazard unit.
REQ-030 One sub-module, flopenrc (parameterised width, async active-low reset, enable, synchronous clear), SHALL implement each pipeline register.

Verification
REQ-031 Reset: hold reset=0 with random D inputs, clocks running -> all outputs 0, Match=4'b1111, StallD=0.
REQ-032 Back-to-back dependency: ADD writing R3, then SUB reading RA1=R3 -> with SUB in E, Match=4'b1000; one cycle later with unrelated E instruction reading RA2=R3 -> Match=4'b0001.
REQ-033 Load-use: LDR R5 (MemtoRegD=1,RegWriteD=1) followed by ADD with RA2D=5 -> StallF=StallD=1 for exactly one cycle, next E contents RegWriteE=0, WA3E=0.
REQ-034 Flush: FlushE=1 while ADD R7 in D -> next cycle RegWriteE=0; three cycles later RegWriteW=0.
REQ-035 Writeback mux: MemtoRegM=1, ReadDataM=32'hDEADBEEF, ALUOutM=32'h1 -> ResultW=32'hDEADBEEF next cycle; MemtoRegM=0 -> ResultW=32'h1.
REQ-036 Simultaneous FlushE and load-use -> single bubble, StallD=1 one cycle, no duplicated or lost instruction in W trace.

Source files
------------

// File: rtl/ex_pipe_regs_pkg.sv
// Shared constants for the execute-stage pipeline registers and the hazard unit.
package ex_pipe_regs_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int RA_W_DEF   = 4;

  // Bit positions inside the Match vector
  localparam int M1EM = 3;
  localparam int M1EW = 2;
  localparam int M2EM = 1;
  localparam int M2EW = 0;
endpackage

// File: rtl/ex_pipe_regs_if.sv
// D/E/M/W pipeline-register bundle; master drives the pipeline, slave holds the registers.
interface ex_pipe_regs_if
  import ex_pipe_regs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF
);
  logic [RA_W-1:0]   RA1D, RA2D, WA3D;
  logic              RegWriteD, MemtoRegD;
  logic [DATA_W-1:0] RD1D, RD2D, ExtImmD;
  logic              FlushE;
  logic [DATA_W-1:0] ALUResultE;
  logic [DATA_W-1:0] ReadDataM;

  logic [RA_W-1:0]   RA1E, RA2E, WA3E;
  logic [DATA_W-1:0] RD1E, RD2E, ExtImmE;
  logic              RegWriteE, MemtoRegE;
  logic [DATA_W-1:0] ALUOutM;
  logic [RA_W-1:0]   WA3M;
  logic              RegWriteM, MemtoRegM;
  logic [DATA_W-1:0] ResultW;
  logic [RA_W-1:0]   WA3W;
  logic              RegWriteW;
  logic [3:0]        Match;
  logic              StallF, StallD;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, RD1D, RD2D, ExtImmD,
           FlushE, ALUResultE, ReadDataM,
    input  RA1E, RA2E, WA3E, RD1E, RD2E, ExtImmE, RegWriteE, MemtoRegE,
           ALUOutM, WA3M, RegWriteM, MemtoRegM, ResultW, WA3W, RegWriteW,
           Match, StallF, StallD
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, RD1D, RD2D, ExtImmD,
           FlushE, ALUResultE, ReadDataM,
    output RA1E, RA2E, WA3E, RD1E, RD2E, ExtImmE, RegWriteE, MemtoRegE,
           ALUOutM, WA3M, RegWriteM, MemtoRegM, ResultW, WA3W, RegWriteW,
           Match, StallF, StallD
  );
endinterface

// File: rtl/ex_pipe_regs_flopenrc.sv
// Pipeline register: async active-low reset, enable, synchronous clear.
module ex_pipe_regs_flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= clr ? '0 : d;
  end
endmodule

// File: rtl/ex_pipe_regs.sv
// D->E, E->M, M->W pipeline registers with forwarding-match and load-use stall detection.
module ex_pipe_regs
  import ex_pipe_regs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ex_pipe_regs_if.slave bus
);
  localparam int EC_W = 3*RA_W + 2;
  localparam int ED_W = 3*DATA_W;
  localparam int M_W  = DATA_W + RA_W + 2;
  localparam int W_W  = DATA_W + RA_W + 1;

  logic              ldr_stall, bubble;
  logic [EC_W-1:0]   ec_q;
  logic [ED_W-1:0]   ed_q;
  logic [M_W-1:0]    m_q;
  logic [W_W-1:0]    w_q;
  logic [DATA_W-1:0] result_m;
  logic [3:0]        match;

  // A load in E whose destination feeds the instruction in D must wait one cycle.
  assign ldr_stall = ((bus.RA1D == bus.WA3E) | (bus.RA2D == bus.WA3E))
                     & bus.MemtoRegE & bus.RegWriteE;
  assign bubble    = bus.FlushE | ldr_stall;
  assign bus.StallF = ldr_stall;
  assign bus.StallD = ldr_stall;

  ex_pipe_regs_flopenrc #(.WIDTH(EC_W)) u_e_ctrl (
    .clk(clk), .reset(reset), .en(1'b1), .clr(bubble),
    .d({bus.RA1D, bus.RA2D, bus.WA3D, bus.RegWriteD, bus.MemtoRegD}),
    .q(ec_q)
  );

  ex_pipe_regs_flopenrc #(.WIDTH(ED_W)) u_e_data (
    .clk(clk), .reset(reset), .en(1'b1), .clr(bubble),
    .d({bus.RD1D, bus.RD2D, bus.ExtImmD}),
    .q(ed_q)
  );

  ex_pipe_regs_flopenrc #(.WIDTH(M_W)) u_m (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
    .d({bus.ALUResultE, bus.WA3E, bus.RegWriteE, bus.MemtoRegE}),
    .q(m_q)
  );

  assign result_m = bus.MemtoRegM ? bus.ReadDataM : bus.ALUOutM;

  ex_pipe_regs_flopenrc #(.WIDTH(W_W)) u_w (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
    .d({result_m, bus.WA3M, bus.RegWriteM}),
    .q(w_q)
  );

  assign {bus.RA1E, bus.RA2E, bus.WA3E, bus.RegWriteE, bus.MemtoRegE} = ec_q;
  assign {bus.RD1E, bus.RD2E, bus.ExtImmE}                            = ed_q;
  assign {bus.ALUOutM, bus.WA3M, bus.RegWriteM, bus.MemtoRegM}        = m_q;
  assign {bus.ResultW, bus.WA3W, bus.RegWriteW}                       = w_q;

  // Ungated by RegWrite; the forwarding unit qualifies these.
  always_comb begin
    match       = '0;
    match[M1EM] = (bus.RA1E == bus.WA3M);
    match[M1EW] = (bus.RA1E == bus.WA3W);
    match[M2EM] = (bus.RA2E == bus.WA3M);
    match[M2EW] = (bus.RA2E == bus.WA3W);
  end
  assign bus.Match = match;
endmodule

// File: tb/tb_ex_pipe_regs.sv
// Directed checks of the execute-stage pipeline registers.
module tb_ex_pipe_regs;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  ex_pipe_regs_if #(.DATA_W(32), .RA_W(4)) bus ();

  ex_pipe_regs #(.DATA_W(32), .RA_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic setd(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                      input logic rw, input logic m2r,
                      input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm);
    bus.RA1D = ra1; bus.RA2D = ra2; bus.WA3D = wa3;
    bus.RegWriteD = rw; bus.MemtoRegD = m2r;
    bus.RD1D = rd1; bus.RD2D = rd2; bus.ExtImmD = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.FlushE = 1'b0; bus.ALUResultE = '0; bus.ReadDataM = '0;
    setd(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1, $urandom, $urandom, $urandom);

    // Reset held with clocks running and random D inputs
    repeat (3) begin
      tick();
      setd(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1, $urandom, $urandom, $urandom);
      bus.ALUResultE = $urandom; bus.ReadDataM = $urandom;
    end
    #1;
    check("rst_RegWriteE", 32'(bus.RegWriteE), 32'h0);
    check("rst_WA3E", 32'(bus.WA3E), 32'h0);
    check("rst_RD1E", bus.RD1E, 32'h0);
    check("rst_ALUOutM", bus.ALUOutM, 32'h0);
    check("rst_ResultW", bus.ResultW, 32'h0);
    check("rst_RegWriteW", 32'(bus.RegWriteW), 32'h0);
    check("rst_Match", 32'(bus.Match), 32'hF);
    check("rst_StallD", 32'(bus.StallD), 32'h0);
    check("rst_StallF", 32'(bus.StallF), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    bus.ALUResultE = '0; bus.ReadDataM = '0;

    // Back-to-back dependency: ADD R3 then SUB reading R3
    setd(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 32'hA1, 32'hA2, 32'hA3);
    tick();
    check("add_WA3E", 32'(bus.WA3E), 32'h3);
    setd(4'd3, 4'd4, 4'd6, 1'b1, 1'b0, 32'h5, 32'h6, 32'h7);
    bus.ALUResultE = 32'h11;
    tick();
    check("sub_Match", 32'(bus.Match), 32'h8);
    check("sub_RD1E", bus.RD1E, 32'h5);
    check("sub_RD2E", bus.RD2E, 32'h6);
    check("sub_ExtImmE", bus.ExtImmE, 32'h7);
    check("add_WA3M", 32'(bus.WA3M), 32'h3);
    setd(4'd8, 4'd3, 4'd9, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.ALUResultE = 32'h22;
    #1;
    check("nodep_StallD", 32'(bus.StallD), 32'h0);
    tick();
    check("rd2_Match", 32'(bus.Match), 32'h1);
    check("add_ResultW", bus.ResultW, 32'h11);
    check("add_WA3W", 32'(bus.WA3W), 32'h3);

    // Load-use: LDR R5 then ADD reading R5
    setd(4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    bus.ALUResultE = 32'h33;
    #1;
    check("pre_ldr_StallD", 32'(bus.StallD), 32'h0);
    tick();
    check("ldr_MemtoRegE", 32'(bus.MemtoRegE), 32'h1);
    setd(4'd6, 4'd5, 4'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.ALUResultE = 32'h1000;
    #1;
    check("lu_StallD", 32'(bus.StallD), 32'h1);
    check("lu_StallF", 32'(bus.StallF), 32'h1);
    tick();
    check("lu_RegWriteE", 32'(bus.RegWriteE), 32'h0);
    check("lu_WA3E", 32'(bus.WA3E), 32'h0);
    check("lu_StallD_after", 32'(bus.StallD), 32'h0);
    check("ldr_MemtoRegM", 32'(bus.MemtoRegM), 32'h1);
    bus.ReadDataM = 32'hDEADBEEF;
    tick();
    check("lu_add_WA3E", 32'(bus.WA3E), 32'h7);
    check("ldr_ResultW", bus.ResultW, 32'hDEADBEEF);
    check("ldr_WA3W", 32'(bus.WA3W), 32'h5);
    check("lu_Match", 32'(bus.Match), 32'h1);
    setd(4'd10, 4'd11, 4'd12, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.ALUResultE = 32'h1;
    tick();
    check("add_ALUOutM", bus.ALUOutM, 32'h1);
    check("bub_RegWriteW", 32'(bus.RegWriteW), 32'h0);

    // Flush with ADD R7 in D; the ALU result must win over ReadDataM
    setd(4'd1, 4'd2, 4'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.FlushE = 1'b1;
    tick();
    check("alu_ResultW", bus.ResultW, 32'h1);
    check("fl_RegWriteE", 32'(bus.RegWriteE), 32'h0);
    check("fl_WA3E", 32'(bus.WA3E), 32'h0);
    bus.FlushE = 1'b0;
    setd(4'd0, 4'd0, 4'd13, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("fl_next_WA3E", 32'(bus.WA3E), 32'hD);
    check("fl_RegWriteM", 32'(bus.RegWriteM), 32'h0);
    setd(4'd14, 4'd14, 4'd14, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("fl_RegWriteW", 32'(bus.RegWriteW), 32'h0);
    check("fl_WA3W", 32'(bus.WA3W), 32'h0);
    tick();
    check("fl_next_WA3W", 32'(bus.WA3W), 32'hD);
    check("fl_next_RegWriteW", 32'(bus.RegWriteW), 32'h1);

    // Simultaneous flush and load-use: one bubble, W trace 9,0,10
    setd(4'd1, 4'd2, 4'd9, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    tick();
    setd(4'd9, 4'd3, 4'd10, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.FlushE = 1'b1;
    #1;
    check("both_StallD", 32'(bus.StallD), 32'h1);
    tick();
    bus.FlushE = 1'b0;
    #1;
    check("both_RegWriteE", 32'(bus.RegWriteE), 32'h0);
    check("both_WA3E", 32'(bus.WA3E), 32'h0);
    check("both_StallD_after", 32'(bus.StallD), 32'h0);
    tick();
    check("both_add_WA3E", 32'(bus.WA3E), 32'hA);
    check("both_W_ldr", 32'(bus.WA3W), 32'h9);
    setd(4'd14, 4'd14, 4'd14, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("both_W_bub", 32'({bus.RegWriteW, bus.WA3W}), 32'h0);
    tick();
    check("both_W_add", 32'({bus.RegWriteW, bus.WA3W}), 32'h1A);
    tick();
    check("both_W_idle", 32'({bus.RegWriteW, bus.WA3W}), 32'hE);

    // Asynchronous reset mid-operation, then first capture after release
    setd(4'd3, 4'd5, 4'd11, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_WA3E", 32'(bus.WA3E), 32'h0);
    check("arst_WA3W", 32'(bus.WA3W), 32'h0);
    check("arst_Match", 32'(bus.Match), 32'hF);
    @(negedge clk);
    reset = 1'b1;
    setd(4'd2, 4'd4, 4'd6, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    check("arst_hold_WA3E", 32'(bus.WA3E), 32'h0);
    tick();
    check("arst_cap_WA3E", 32'(bus.WA3E), 32'h6);
    check("arst_cap_RA2E", 32'(bus.RA2E), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
